// File: rtl/pulse_readout_sequencer_if.sv
// Bus between the readout sequencer and the counter bank / top-level outputs.
// The master side is the sequencer; the slave side is the counter bank and its observers.
interface pulse_readout_sequencer_if #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 3
);
  logic [CNT_W-1:0]  cnt_data;
  logic              ovf_ch_in;
  logic [ADDR_W-1:0] addr;
  logic              sl;
  logic              cnt_clr;
  logic              serial_out;
  logic              busy;
  logic              ovf_global;
  logic              ovf_rtc;

  modport master (
    input  cnt_data, ovf_ch_in,
    output addr, sl, cnt_clr, serial_out, busy, ovf_global, ovf_rtc
  );

  modport slave (
    output cnt_data, ovf_ch_in,
    input  addr, sl, cnt_clr, serial_out, busy, ovf_global, ovf_rtc
  );
endinterface

// File: rtl/pulse_readout_sequencer.sv
// Per RTC tick: walk every channel, capture+clear its counter and shift the count out
// serially (overflow bit first, then data MSB first), framed by a leading marker bit.
//
// state | meaning
// IDLE  | waiting for a synchronised RTC rising edge
// START | frame marker on serial_out, frame accumulators cleared
// LOAD  | addressed counter captured into the shift register and cleared
// SHIFT | CNT_W+1 bits of the captured channel shifted out
// DONE  | frame overflow summary published to ovf_global
module pulse_readout_sequencer #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rtc,
  pulse_readout_sequencer_if.master  bus
);

  if (N_CH < 1 || N_CH > (1 << ADDR_W)) begin : g_bad_n_ch
    $error("N_CH must be between 1 and 2**ADDR_W");
  end

  localparam int                BIT_W    = $clog2(CNT_W + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(CNT_W);
  localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(N_CH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              sync3_q, sync3_d;
  logic [ADDR_W-1:0] ch_idx_q, ch_idx_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W:0]    sr_q, sr_d;
  logic              acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sl_q, sl_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              serial_out_q, serial_out_d;
  logic              busy_q, busy_d;
  logic              ovf_global_q, ovf_global_d;
  logic              ovf_rtc_q, ovf_rtc_d;
  logic              rise;

  always_comb begin
    rise         = sync2_q & ~sync3_q;
    sync1_d      = rtc;
    sync2_d      = sync1_q;
    sync3_d      = sync2_q;
    state_d      = state_q;
    ch_idx_d     = ch_idx_q;
    bit_idx_d    = bit_idx_q;
    sr_d         = sr_q;
    acc_d        = acc_q;
    ovf_global_d = ovf_global_q;
    ovf_rtc_d    = ovf_rtc_q;

    // An edge seen outside IDLE (DONE included) is dropped, only flagged.
    if (rise && (state_q != IDLE)) begin
      ovf_rtc_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = START;
        end
      end
      START: begin
        ch_idx_d = '0;
        acc_d    = 1'b0;
        state_d  = LOAD;
      end
      LOAD: begin
        sr_d      = {bus.ovf_ch_in, bus.cnt_data};
        acc_d     = acc_q | bus.ovf_ch_in;
        bit_idx_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        sr_d = {sr_q[CNT_W-1:0], 1'b0};
        if (bit_idx_q == LAST_BIT) begin
          if (ch_idx_q == LAST_CH) begin
            state_d = DONE;
          end else begin
            ch_idx_d = ch_idx_q + 1'b1;
            state_d  = LOAD;
          end
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    addr_d       = ((state_d == LOAD) || (state_d == SHIFT)) ? ch_idx_d : '0;
    sl_d         = (state_d == LOAD);
    cnt_clr_d    = (state_d == LOAD);
    busy_d       = (state_d != IDLE);
    serial_out_d = 1'b0;
    if (state_d == START) begin
      serial_out_d = 1'b1;
    end else if (state_d == SHIFT) begin
      serial_out_d = sr_d[CNT_W];
    end
    if (state_d == DONE) begin
      ovf_global_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      ch_idx_q     <= '0;
      bit_idx_q    <= '0;
      sr_q         <= '0;
      acc_q        <= 1'b0;
      addr_q       <= '0;
      sl_q         <= 1'b0;
      cnt_clr_q    <= 1'b0;
      serial_out_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_global_q <= 1'b0;
      ovf_rtc_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      ch_idx_q     <= ch_idx_d;
      bit_idx_q    <= bit_idx_d;
      sr_q         <= sr_d;
      acc_q        <= acc_d;
      addr_q       <= addr_d;
      sl_q         <= sl_d;
      cnt_clr_q    <= cnt_clr_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      ovf_global_q <= ovf_global_d;
      ovf_rtc_q    <= ovf_rtc_d;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.sl         = sl_q;
  assign bus.cnt_clr    = cnt_clr_q;
  assign bus.serial_out = serial_out_q;
  assign bus.busy       = busy_q;
  assign bus.ovf_global = ovf_global_q;
  assign bus.ovf_rtc    = ovf_rtc_q;

endmodule

// File: doc/pulse_readout_sequencer.md
Name: pulse_readout_sequencer

Overview:
- Controller for the multichannel pulse-counter datapath.
- On each RTC rising edge it runs one readout frame: for every channel it selects the counter through the address bus, pulses shift/load to capture the count, clears that counter, and shifts the count out serially, MSB first, with a per-channel overflow bit prepended.
- Sits between the channel counter bank / address mux and the top-level serial, overflow and status outputs.

Parameters:
- N_CH, 4, number of channels read per frame; must satisfy 1 <= N_CH <= 2**ADDR_W.
- CNT_W, 8, width of each channel counter.
- ADDR_W, 3, width of the channel address bus.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rtc  in  1  raw RTC tick input, asynchronous to clk.
- cnt_data  in  CNT_W  count of the currently addressed channel, from the external mux.
- ovf_ch_in  in  1  overflow flag of the currently addressed channel.
- addr  out  ADDR_W  channel select to the counter mux.
- sl  out  1  shift/load: 1 = load cycle, 0 = otherwise.
- cnt_clr  out  1  clear strobe to the addressed counter, high in the load cycle only.
- serial_out  out  1  serial frame data.
- busy  out  1  high from START through DONE inclusive.
- ovf_global  out  1  OR of all channel overflow bits captured in the last completed frame.
- ovf_rtc  out  1  sticky flag: an RTC edge arrived while busy.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - addr = 0, sl = 0, cnt_clr = 0, serial_out = 0, busy = 0, ovf_global = 0, ovf_rtc = 0.
  - state = IDLE; synchroniser flops = 0.
- RTC input path:
  - rtc passes through a 2-flop synchroniser, then a third flop for edge detection.
  - rise = sync2 & ~sync3.
  - START is entered on the clock edge after rise is high, i.e. 3 clk edges after the first edge that samples rtc = 1.
  - An rtc high pulse shorter than one clk period is not guaranteed to be detected.
- FSM states: IDLE, START, LOAD, SHIFT, DONE. All outputs are registered and decoded from the state and counters.
- IDLE:
  - addr = 0, sl = 0, serial_out = 0, busy = 0.
  - rise -> START.
- START (1 cycle):
  - serial_out = 1 (frame marker), busy = 1.
  - ch_idx <= 0; frame overflow accumulator <= 0.
  - -> LOAD.
- LOAD (1 cycle):
  - addr = ch_idx, sl = 1, cnt_clr = 1, serial_out = 0.
  - Shift register (CNT_W+1 bits) <= {ovf_ch_in, cnt_data}, sampled at the end of this cycle.
  - acc |= ovf_ch_in.
  - Counter contract: the counter captures its value and clears in the same cycle; a pulse arriving in that cycle is counted after the clear.
  - -> SHIFT with bit_idx = 0.
- SHIFT (CNT_W+1 cycles):
  - sl = 0; addr holds ch_idx.
  - serial_out = shift-register MSB; the register shifts left by 1 each cycle.
  - Bit order: overflow bit first, then cnt_data[CNT_W-1] down to bit 0.
  - After bit CNT_W: if ch_idx == N_CH-1 -> DONE; else ch_idx + 1 -> LOAD.
- DONE (1 cycle):
  - serial_out = 0, busy = 1.
  - ovf_global <= acc.
  - -> IDLE.
- Frame length = 2 + N_CH*(CNT_W+2) cycles, START through DONE; 42 cycles with defaults.
- ovf_rtc:
  - Set when rise occurs in any state other than IDLE; that edge is discarded, with no queueing.
  - Stays set until reset.
  - A rise in the same cycle as DONE counts as while busy: set ovf_rtc, do not start.
- ovf_global changes only in DONE and holds between frames.
- Reset asserted mid-frame: next clock returns all outputs to reset values and the frame is abandoned. Counters are not cleared for channels not yet visited.
- ch_idx and bit_idx never exceed N_CH-1 and CNT_W respectively; no wrap-around beyond those bounds.

Test Plan:
- Reset, then rtc held 0 for 100 cycles -> busy = 0, serial_out = 0, addr = 0, all flags 0.
- Counts ch0..ch3 = 0xA5, 0x01, 0xFF, 0x00, all ovf 0; one rtc rise -> START 3 edges later, 42-cycle frame.
  - serial stream: 1, then per channel 0 (load), 0, then 8 data bits MSB first, e.g. 10100101 for ch0.
  - sl and cnt_clr high exactly at frame cycles 1, 11, 21, 31; addr steps 0..3; ovf_global = 0.
- ovf_ch_in = 1 on ch2 only -> overflow bit of the ch2 slot = 1, ovf_global goes 1 at DONE.
  - Next frame with no overflow -> ovf_global returns 0 at that frame's DONE.
- Second rtc rise 20 cycles into a frame -> frame completes unchanged, ovf_rtc = 1 and stays 1, no second frame starts.
  - Later rise while IDLE -> new frame starts, ovf_rtc remains 1.
- Reset asserted during the SHIFT of ch1 -> next cycle busy = 0, serial_out = 0, addr = 0.
  - Following rtc rise produces a complete, correct frame.
- rtc pulse high for exactly 1 clk period, aligned to a clk edge -> exactly one frame.
  - rtc held high for 200 cycles -> exactly one frame; no retrigger until rtc falls and rises again.
